apb_initiator: RTL and testbench
================================

# apb_initiator

Synchronous APB3 initiator (requester) that converts a single-beat valid/ready command into a compliant APB SETUP/ACCESS transfer. It drives the completer side of the `apb_if` bundle (`paddr`, `pwrite`, `psel`, `penable`, `pwdata`) and samples `pready`, `prdata` and `pslverr`. The captured outcome is returned on a valid/ready response channel. It sits between the aligner's configuration/test controller and the APB register completer, with a bounded wait-state timeout so a hung completer cannot stall the controller.

## Interface
- ADDR_WIDTH, 32, APB address width (≤ `AY_APB_MAX_ADDR_WIDTH`)
- DATA_WIDTH, 32, APB data width (≤ `AY_APB_MAX_DATA_WIDTH`)
- TIMEOUT_CYCLES, 16, max ACCESS cycles with `pready`=0 before abort; 0 disables timeout
- clk  in  1  single clock; all logic on rising edge
- preset  in  1  reset, synchronous, active-high
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when req_valid && req_ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  transfer address
- req_wdata  in  DATA_WIDTH  write data (ignored for reads)
- rsp_valid  out  1  response valid; held until rsp_ready
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and timeouts)
- rsp_slverr  out  1  completer error or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- paddr  out  ADDR_WIDTH  APB address
- pwrite  out  1  APB direction
- psel  out  1  APB select
- penable  out  1  APB enable
- pwdata  out  DATA_WIDTH  APB write data
- pready  in  1  completer ready
- prdata  in  DATA_WIDTH  completer read data
- pslverr  in  1  completer error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: req_ready=1 and psel=penable=0. On handshake, latch addr, write and wdata, then go to SETUP.
- SETUP (exactly 1 cycle): psel=1, penable=0, paddr/pwrite/pwdata driven from latches. Go to ACCESS.
- ACCESS: psel=1, penable=1, all APB outputs held stable.
  - pready=1: capture prdata (reads only, else 0) and pslverr, go to RESP.
  - pready=0: increment wait counter.
  - Timeout: if TIMEOUT_CYCLES≠0 and counter reaches TIMEOUT_CYCLES with pready still 0, go to RESP with rsp_slverr=1, rsp_timeout=1, rsp_rdata=0.
- RESP: psel=penable=0, rsp_valid=1 and response fields stable. On rsp_ready=1, go to IDLE.
- req_ready is 0 in SETUP, ACCESS and RESP. At most one outstanding transfer.
- pwdata is the latched wdata for writes and 0 for reads.
- paddr/pwrite hold their last value in IDLE/RESP (no glitch to 0 required), except after reset.
- Wait counter is ⌈log2(TIMEOUT_CYCLES+1)⌉ bits and clears on entry to ACCESS.
- Reset values: req_ready=0 during the reset cycle, then 1 in IDLE. rsp_valid=0, rsp_rdata=0, rsp_slverr=0, rsp_timeout=0, paddr=0, pwrite=0, psel=0, penable=0, pwdata=0. State=IDLE.
- Reset mid-transfer: on the next edge, the FSM returns to IDLE, APB outputs go to their reset values, the transfer is dropped and no response is produced.
- pslverr is sampled only in the cycle where penable=1 and pready=1. It is ignored otherwise.

## Timing
- Cycle 0: handshake. Cycle 1: SETUP. Cycle 2: first ACCESS. Response valid at cycle 3 + N, where N = number of pready=0 ACCESS cycles.
- Zero-wait throughput: one transfer per 4 cycles when rsp_ready=1 in the first RESP cycle (RESP → IDLE → accept).
- rsp_ready asserted in the first RESP cycle: rsp_valid lasts exactly 1 cycle.
- Timeout abort: the ACCESS phase lasts exactly TIMEOUT_CYCLES cycles, then RESP.
- pready=1 in the same cycle the counter reaches the limit: the completion wins, with normal response and rsp_timeout=0.
- No combinational path from APB inputs to APB outputs. rsp_* are registered.

## Test plan
- Write 0x0000_0010 ← 0xDEAD_BEEF, pready=1 immediately → psel rises at cycle 1, penable at cycle 2, pwrite=1, pwdata=0xDEADBEEF, and rsp_valid at cycle 3 with slverr=0 and rdata=0.
- Read 0x0000_0004 with 3 wait states, prdata=0x1234_5678 → ACCESS lasts 4 cycles, APB outputs stable throughout, rsp_rdata=0x12345678.
- Read with pslverr=1 on the ready cycle → rsp_slverr=1, rsp_timeout=0.
- TIMEOUT_CYCLES=16 and pready held 0 → abort after 16 ACCESS cycles with rsp_slverr=1, rsp_timeout=1, rdata=0. Also pready=1 on the 16th cycle → normal completion.
- Back-to-back writes with rsp_ready tied 1 → accepted every 4 cycles. rsp_ready held 0 for 5 cycles → rsp_valid held, req_ready=0, no new APB transfer.
- preset asserted during ACCESS → next edge psel=penable=0, rsp_valid=0, req_ready=1 one cycle after reset release, and no response is ever emitted.

Source files
------------

// File: rtl/apb_initiator_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_initiator_if
// Brief    : APB3 bus bundle between an initiator and a register completer.
// Revision : 1.0
// ============================================================================
interface apb_initiator_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0] paddr;
    logic                  pwrite;
    logic                  psel;
    logic                  penable;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pready;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pslverr;

    modport master (
        output paddr, pwrite, psel, penable, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, pwrite, psel, penable, pwdata,
        output pready, prdata, pslverr
    );
endinterface
`default_nettype wire

// File: rtl/apb_initiator.sv
`default_nettype none
// ============================================================================
// Module   : apb_initiator
// Brief    : Single-beat valid/ready command to APB3 SETUP/ACCESS transfer,
//            with a bounded wait-state timeout and a registered response.
// Revision : 1.0
// ============================================================================
module apb_initiator #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic                  clk,
    input  wire logic                  preset,
    input  wire logic                  req_valid,
    output logic                       req_ready,
    input  wire logic                  req_write,
    input  wire logic [ADDR_WIDTH-1:0] req_addr,
    input  wire logic [DATA_WIDTH-1:0] req_wdata,
    output logic                       rsp_valid,
    input  wire logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_rdata,
    output logic                       rsp_slverr,
    output logic                       rsp_timeout,
    apb_initiator_if.master            apb
);

    localparam int c_CNT_W     = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_TO_LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [c_CNT_W-1:0] c_TO_LAST = c_TO_LAST_I[c_CNT_W-1:0];
    localparam bit c_TO_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_req_ready;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic                  r_pwrite;
    logic                  r_psel;
    logic                  r_penable;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [c_CNT_W-1:0]    r_wait_cnt;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_slverr;
    logic                  r_rsp_timeout;

    always_ff @(posedge clk) begin
        if (preset) begin
            r_state       <= S_IDLE;
            r_req_ready   <= 1'b0;
            r_paddr       <= '0;
            r_pwrite      <= 1'b0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwdata      <= '0;
            r_wait_cnt    <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_slverr  <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // req_ready is registered, so it comes up one cycle after reset
                    if (r_req_ready && req_valid) begin
                        r_req_ready <= 1'b0;
                        r_paddr     <= req_addr;
                        r_pwrite    <= req_write;
                        r_pwdata    <= req_write ? req_wdata : '0;
                        r_psel      <= 1'b1;
                        r_state     <= S_SETUP;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                S_SETUP: begin
                    r_penable  <= 1'b1;
                    r_wait_cnt <= '0;
                    r_state    <= S_ACCESS;
                end
                S_ACCESS: begin
                    // Completion takes priority over a timeout in the same cycle
                    if (apb.pready) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= r_pwrite ? '0 : apb.prdata;
                        r_rsp_slverr  <= apb.pslverr;
                        r_rsp_timeout <= 1'b0;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_state       <= S_RESP;
                    end else if (c_TO_EN && (r_wait_cnt == c_TO_LAST)) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_rsp_slverr  <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_state       <= S_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_slverr  = r_rsp_slverr;
    assign rsp_timeout = r_rsp_timeout;

    assign apb.paddr   = r_paddr;
    assign apb.pwrite  = r_pwrite;
    assign apb.psel    = r_psel;
    assign apb.penable = r_penable;
    assign apb.pwdata  = r_pwdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_initiator
// Brief    : Directed self-checking bench for apb_initiator.
// Revision : 1.0
// ============================================================================
module tb_apb_initiator;

    logic        clk;
    logic        preset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr;
    logic        rsp_timeout;

    int n_cmp;
    int n_err;

    apb_initiator_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) apb ();

    apb_initiator #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk        (clk),
        .preset     (preset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_slverr (rsp_slverr),
        .rsp_timeout(rsp_timeout),
        .apb        (apb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transfer; entered in an IDLE cycle with req_ready already high
    task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input int nwait, input logic [31:0] rd, input bit err,
                        input logic [31:0] exp_rdata, input bit exp_err, input bit exp_to,
                        input int exp_access, input int hold);
        logic [31:0] exp_pwdata;
        exp_pwdata = w ? d : 32'h0;
        check_val("idle_req_ready", req_ready, 1);
        check_val("idle_psel", apb.psel, 0);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        tick();
        req_valid = 1'b0;
        req_wdata = 32'hFFFF_FFFF;
        check_val("setup_psel", apb.psel, 1);
        check_val("setup_penable", apb.penable, 0);
        check_val("setup_req_ready", req_ready, 0);
        check_val("setup_paddr", apb.paddr, a);
        check_val("setup_pwrite", apb.pwrite, w);
        check_val("setup_pwdata", apb.pwdata, exp_pwdata);
        tick();
        for (int i = 0; i < exp_access; i++) begin
            check_val("access_psel", apb.psel, 1);
            check_val("access_penable", apb.penable, 1);
            check_val("access_paddr", apb.paddr, a);
            check_val("access_pwrite", apb.pwrite, w);
            check_val("access_pwdata", apb.pwdata, exp_pwdata);
            check_val("access_rsp_valid", rsp_valid, 0);
            apb.pready  = (i == nwait);
            apb.prdata  = (i == nwait) ? rd : (32'hBAD0_0000 + 32'(i));
            apb.pslverr = (i == nwait) ? err : 1'b1;
            tick();
        end
        apb.pready  = 1'b0;
        apb.pslverr = 1'b0;
        for (int j = 0; j <= hold; j++) begin
            check_val("resp_valid", rsp_valid, 1);
            check_val("resp_rdata", rsp_rdata, exp_rdata);
            check_val("resp_slverr", rsp_slverr, exp_err);
            check_val("resp_timeout", rsp_timeout, exp_to);
            check_val("resp_psel", apb.psel, 0);
            check_val("resp_penable", apb.penable, 0);
            check_val("resp_req_ready", req_ready, 0);
            req_valid = (j < hold);
            rsp_ready = (j == hold);
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        check_val("post_rsp_valid", rsp_valid, 0);
        check_val("post_req_ready", req_ready, 1);
        check_val("post_psel", apb.psel, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit rsp_seen;
        n_cmp       = 0;
        n_err       = 0;
        preset      = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = 32'h0;
        req_wdata   = 32'h0;
        rsp_ready   = 1'b0;
        apb.pready  = 1'b0;
        apb.prdata  = 32'h0;
        apb.pslverr = 1'b0;
        tick();
        tick();
        check_val("rst_req_ready", req_ready, 0);
        check_val("rst_rsp_valid", rsp_valid, 0);
        check_val("rst_rsp_rdata", rsp_rdata, 0);
        check_val("rst_rsp_slverr", rsp_slverr, 0);
        check_val("rst_rsp_timeout", rsp_timeout, 0);
        check_val("rst_paddr", apb.paddr, 0);
        check_val("rst_pwrite", apb.pwrite, 0);
        check_val("rst_psel", apb.psel, 0);
        check_val("rst_penable", apb.penable, 0);
        check_val("rst_pwdata", apb.pwdata, 0);
        preset = 1'b0;
        tick();

        //   w  addr          wdata         nw   prdata        err  exp_rdata     e  to acc hold
        xfer(1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h7777_7777, 0, 32'h0000_0000, 0, 0, 1, 0);
        xfer(0, 32'h0000_0004, 32'h1111_1111, 3, 32'h1234_5678, 0, 32'h1234_5678, 0, 0, 4, 0);
        xfer(0, 32'h0000_0008, 32'h0,         1, 32'hCAFE_0001, 1, 32'hCAFE_0001, 1, 0, 2, 0);
        xfer(0, 32'h0000_000C, 32'h0,       100, 32'h9999_9999, 0, 32'h0000_0000, 1, 1, 16, 0);
        xfer(0, 32'h0000_0020, 32'h0,        15, 32'h0F0F_0F0F, 0, 32'h0F0F_0F0F, 0, 0, 16, 0);
        xfer(1, 32'h0000_0024, 32'h55AA_55AA, 2, 32'hABCD_EF01, 1, 32'h0000_0000, 1, 0, 3, 0);
        xfer(1, 32'h0000_0028, 32'h0BAD_F00D, 0, 32'h0,         0, 32'h0000_0000, 0, 0, 1, 5);

        // Back-to-back writes, rsp_ready tied high: one accept every 4 cycles
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_addr   = 32'h0000_0100;
        rsp_ready  = 1'b1;
        apb.pready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            check_val("b2b_req_ready", req_ready, (i % 4) == 0);
            check_val("b2b_rsp_valid", rsp_valid, (i % 4) == 3);
            check_val("b2b_psel", apb.psel, ((i % 4) == 1) || ((i % 4) == 2));
            check_val("b2b_penable", apb.penable, (i % 4) == 2);
            if ((i % 4) == 1)
                check_val("b2b_pwdata", apb.pwdata, 32'hA000_0000 + 32'(i - 1));
            req_wdata = 32'hA000_0000 + 32'(i);
            tick();
        end
        req_valid  = 1'b0;
        rsp_ready  = 1'b0;
        apb.pready = 1'b0;
        tick();
        check_val("b2b_idle_psel", apb.psel, 0);

        // Reset during ACCESS drops the transfer
        check_val("mid_req_ready", req_ready, 1);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0000_0200;
        req_wdata = 32'h1357_9BDF;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check_val("mid_access_penable", apb.penable, 1);
        preset = 1'b1;
        tick();
        preset = 1'b0;
        check_val("mid_rst_psel", apb.psel, 0);
        check_val("mid_rst_penable", apb.penable, 0);
        check_val("mid_rst_rsp_valid", rsp_valid, 0);
        check_val("mid_rst_req_ready", req_ready, 0);
        check_val("mid_rst_paddr", apb.paddr, 0);
        check_val("mid_rst_pwdata", apb.pwdata, 0);
        apb.pready = 1'b1;
        tick();
        check_val("mid_rel_req_ready", req_ready, 1);
        rsp_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid || apb.psel) rsp_seen = 1'b1;
            tick();
        end
        check_val("mid_no_response", rsp_seen, 0);
        apb.pready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
